// File: rtl/apu_dma_pkg.sv
// apu_dma_pkg: shared state encoding and constants for the APU DMA controller
package apu_dma_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_DMC_DUMMY,
    S_ALIGN,
    S_DMC_READ,
    S_OAM_READ,
    S_OAM_WRITE
  } state_e;
  localparam logic [15:0] OAMDATA_ADDR_DEF = 16'h2004;
  localparam logic PARITY_GET = 1'b0;
endpackage

// File: rtl/apu_dma_ctrl.sv
// apu_dma_ctrl: halts the 6502 and owns the bus for DMC sample fetches and OAM sprite DMA
module apu_dma_ctrl
  import apu_dma_pkg::*;
#(
  parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_clk,
  input  logic        cpu_rw,
  input  logic        oam_wren,
  input  logic [7:0]  from_cpu,
  input  logic        dma_req,
  input  logic [14:0] dma_address,
  output logic        dma_ack,
  input  logic [7:0]  from_mem,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] bus_address,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata
);
  state_e      state_q, state_d;
  logic        parity_q, parity_d;
  logic        oam_pend_q, oam_pend_d;
  logic        dmc_pend_q, dmc_pend_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rdy_q, rdy_d;
  logic        active_q, active_d;
  logic        ack_q, ack_d;
  logic        rw_q, rw_d;
  logic [15:0] addr_q, addr_d;
  logic        next_get;
  logic        dmc_set;
  assign next_get = parity_q != PARITY_GET;
  assign dmc_set  = dma_req && !dmc_pend_q && state_q != S_DMC_READ;
  // Everything here is the value to load at the next cpu_clk strobe.
  always_comb begin
    state_d    = state_q;
    parity_d   = ~parity_q;
    oam_pend_d = oam_pend_q;
    dmc_pend_d = dmc_pend_q | dmc_set;
    page_d     = page_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (oam_wren && !oam_pend_q) begin
          oam_pend_d = 1'b1;
          page_d     = from_cpu;
        end
        state_d = (oam_wren || dma_req) ? S_HALT : S_IDLE;
      end
      S_HALT:      state_d = !cpu_rw ? S_HALT : dmc_pend_q ? S_DMC_DUMMY : next_get ? S_OAM_READ : S_ALIGN;
      S_DMC_DUMMY: state_d = next_get ? S_DMC_READ : S_ALIGN;
      S_ALIGN:     state_d = dmc_pend_q ? S_DMC_READ : S_OAM_READ;
      S_DMC_READ: begin
        dmc_pend_d = 1'b0;
        state_d    = !oam_pend_q ? S_IDLE : next_get ? S_OAM_READ : S_ALIGN;
      end
      S_OAM_READ: begin
        wdata_d = from_mem;
        state_d = S_OAM_WRITE;
      end
      S_OAM_WRITE: begin
        index_d    = index_q + 8'd1;
        oam_pend_d = index_q != 8'hFF;
        state_d    = dmc_pend_d ? S_DMC_READ : index_q == 8'hFF ? S_IDLE : S_OAM_READ;
      end
      default: state_d = S_IDLE;
    endcase
    rdy_d    = state_d == S_IDLE;
    active_d = !(state_d inside {S_IDLE, S_HALT});
    ack_d    = state_d == S_DMC_READ;
    rw_d     = state_d != S_OAM_WRITE;
    addr_d   = state_d == S_DMC_READ  ? {1'b1, dma_address} :
               state_d == S_OAM_READ  ? {page_d, index_d} :
               state_d == S_OAM_WRITE ? OAMDATA_ADDR : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      parity_q   <= 1'b0;
      oam_pend_q <= 1'b0;
      dmc_pend_q <= 1'b0;
      page_q     <= 8'h00;
      index_q    <= 8'h00;
      wdata_q    <= 8'h00;
      rdy_q      <= 1'b1;
      active_q   <= 1'b0;
      ack_q      <= 1'b0;
      rw_q       <= 1'b1;
      addr_q     <= 16'h0000;
    end else if (cpu_clk) begin
      state_q    <= state_d;
      parity_q   <= parity_d;
      oam_pend_q <= oam_pend_d;
      dmc_pend_q <= dmc_pend_d;
      page_q     <= page_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
      rdy_q      <= rdy_d;
      active_q   <= active_d;
      ack_q      <= ack_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
    end
  end
  assign cpu_rdy     = rdy_q;
  assign dma_active  = active_q;
  assign dma_ack     = ack_q;
  assign bus_rw      = rw_q;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
endmodule

// File: tb/tb_apu_dma_ctrl.sv
// tb_apu_dma_ctrl: builds the expected per-CPU-cycle bus schedule of each DMA episode and checks the DUT against it
module tb_apu_dma_ctrl;
  typedef struct {
    bit rdy, act, ack, chk, e_rw, wr, req, wren, i_rw;
    logic [15:0] addr;
    logic [7:0]  wd, pg;
  } cyc_t;
  logic        clk = 1'b0, rst = 1'b1, cpu_clk = 1'b0, cpu_rw = 1'b1, oam_wren = 1'b0, dma_req = 1'b0;
  logic [7:0]  from_cpu = 8'h00, from_mem;
  logic [14:0] dma_address = 15'h0;
  logic        dma_ack, cpu_rdy, dma_active, bus_rw;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic [7:0]  mem [256];
  logic [7:0]  dmc_data;
  cyc_t        q[$];
  int          cyc, nxt, errors, checks, low_cnt;

  apu_dma_ctrl dut (
    .clk(clk), .rst(rst), .cpu_clk(cpu_clk), .cpu_rw(cpu_rw), .oam_wren(oam_wren),
    .from_cpu(from_cpu), .dma_req(dma_req), .dma_address(dma_address), .dma_ack(dma_ack),
    .from_mem(from_mem), .cpu_rdy(cpu_rdy), .dma_active(dma_active),
    .bus_address(bus_address), .bus_rw(bus_rw), .bus_wdata(bus_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] memv(input logic [15:0] a);
    return a[15] ? (a == 16'hC000 ? 8'hA5 : a[7:0] ^ 8'h3C) : mem[a[7:0]] ^ a[15:8];
  endfunction
  assign from_mem = memv(bus_address);

  function automatic cyc_t mk(input bit rdy, input bit act);
    cyc_t c = '{default: '0};
    c.rdy  = rdy;
    c.act  = act;
    c.i_rw = 1'b1;
    return c;
  endfunction

  function automatic void push(input cyc_t c);
    q.push_back(c);
    nxt++;
  endfunction

  function automatic void xfer(input logic [15:0] a, input bit rw, input bit ack, input bit wr,
                               input logic [7:0] wd, input bit req);
    cyc_t c = mk(1'b0, 1'b1);
    c.chk = 1'b1; c.addr = a; c.e_rw = rw; c.ack = ack; c.wr = wr; c.wd = wd; c.req = req;
    push(c);
  endfunction

  // bus transfers must start on a get (even) cycle; an owned idle put cycle fills the gap
  function automatic void align();
    if (nxt % 2 == 1) push(mk(1'b0, 1'b1));
  endfunction

  function automatic void build_oam(input logic [7:0] pg, input int k);
    cyc_t c = mk(1'b1, 1'b0);
    nxt = cyc;
    c.i_rw = 1'b0; c.wren = 1'b1; c.pg = pg;
    push(c);
    push(mk(1'b0, 1'b0));
    align();
    for (int i = 0; i < 256; i++) begin
      xfer({pg, 8'(i)}, 1'b1, 1'b0, 1'b0, 8'h00, i == k);
      xfer(16'h2004, 1'b0, 1'b0, 1'b1, memv({pg, 8'(i)}), 1'b0);
      if (i == k) begin
        xfer({1'b1, dma_address}, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        push(mk(1'b0, 1'b1));
      end
    end
    push(mk(1'b1, 1'b0));
  endfunction

  function automatic void build_dmc(input int nw);
    cyc_t c = mk(1'b1, 1'b0);
    nxt = cyc;
    c.req = 1'b1; c.i_rw = 1'($urandom);
    push(c);
    repeat (nw) begin
      c = mk(1'b0, 1'b0);
      c.i_rw = 1'b0;
      push(c);
    end
    push(mk(1'b0, 1'b0));
    push(mk(1'b0, 1'b1));
    align();
    xfer({1'b1, dma_address}, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    push(mk(1'b1, 1'b0));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1 cpu_clk = 1'b1;
    @(posedge clk);
    #1 cpu_clk = 1'b0;
    cyc++;
  endtask

  task automatic run(input int limit);
    for (int k = 0; k < limit && q.size() > 0; k++) begin
      cyc_t c;
      logic got;
      c = q.pop_front();
      chk("rdy", 16'(cpu_rdy), 16'(c.rdy));
      chk("active", 16'(dma_active), 16'(c.act));
      chk("ack", 16'(dma_ack), 16'(c.ack));
      if (c.chk) begin
        chk("addr", bus_address, c.addr);
        chk("bus_rw", 16'(bus_rw), 16'(c.e_rw));
      end
      if (c.wr) chk("wdata", 16'(bus_wdata), 16'(c.wd));
      if (!cpu_rdy) low_cnt++;
      cpu_rw   = c.i_rw;
      oam_wren = c.wren;
      from_cpu = c.pg;
      if (c.req) dma_req = 1'b1;
      got = dma_ack;
      if (got) dmc_data = from_mem;
      step();
      oam_wren = 1'b0;
      if (got) dma_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc_t c = mk(1'b1, 1'b0);
      c.i_rw = 1'($urandom);
      q.push_back(c);
    end
    run(n);
  endtask

  task automatic pad(input int par);
    if ((cyc & 1) != par) idle(1);
  endtask

  task automatic stall(input string tag, input int exp);
    chk(tag, 16'(low_cnt), 16'(exp));
    low_cnt = 0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_rdy"}, 16'(cpu_rdy), 16'h1);
    chk({tag, "_active"}, 16'(dma_active), 16'h0);
    chk({tag, "_ack"}, 16'(dma_ack), 16'h0);
    chk({tag, "_rw"}, 16'(bus_rw), 16'h1);
    chk({tag, "_addr"}, bus_address, 16'h0000);
    chk({tag, "_wdata"}, 16'(bus_wdata), 16'h0000);
  endtask

  initial begin
    logic [7:0] pg;
    int par;
    errors = 0; checks = 0; cyc = 0; low_cnt = 0; dmc_data = 8'h00;
    foreach (mem[i]) mem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    reset_chk("reset");
    pad(0);
    low_cnt = 0;
    build_oam(8'h02, -1);
    run(10000);
    stall("oam_get_stall", 513);
    idle(3);
    pad(1);
    low_cnt = 0;
    build_oam(8'($urandom), -1);
    run(10000);
    stall("oam_put_stall", 514);
    dma_address = 15'h4000;
    for (int p = 0; p < 2; p++) begin
      pad(p);
      low_cnt = 0;
      dmc_data = 8'h00;
      build_dmc(0);
      run(100);
      chk("dmc_data", 16'(dmc_data), 16'h00A5);
      stall("dmc_stall", p == 1 ? 3 : 4);
      idle(2);
    end
    dma_address = 15'($urandom);
    pad(0);
    low_cnt = 0;
    dmc_data = 8'h00;
    build_dmc(2);
    run(100);
    stall("dmc_wr_stall", 6);
    chk("dmc_wr_data", 16'(dmc_data), 16'(memv({1'b1, dma_address})));
    par = int'($urandom_range(1, 0));
    idle(2);
    pad(par);
    dma_address = 15'($urandom);
    low_cnt = 0;
    dmc_data = 8'h00;
    build_oam(8'($urandom), 16);
    run(10000);
    stall("interleave_stall", 515 + par);
    chk("interleave_data", 16'(dmc_data), 16'(memv({1'b1, dma_address})));
    idle(1);
    pad(0);
    pg = 8'($urandom);
    build_oam(pg, -1);
    run(258);
    chk("idx80_addr", bus_address, {pg, 8'h80});
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    q.delete();
    reset_chk("midrst");
    idle(2);
    pad(0);
    low_cnt = 0;
    build_oam(8'($urandom), -1);
    run(10000);
    stall("restart_stall", 513);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
